// File: rtl/ddr3_walk_tester.sv
// ddr3_walk_tester: Avalon-MM memory self-test master.
// On a start pulse it writes a seeded, incrementing 32-bit pattern (replicated
// across the data bus) to a strided window of words. It then reads each word
// back, one read outstanding at a time, and reports the mismatch count, the
// first failing address, a read timeout and an overall pass/fail.
module ddr3_walk_tester #(
    parameter int          ADDR_W     = 26,
    parameter int          DATA_W     = 128,
    parameter int          START_ADDR = 0,
    parameter int          NUM_WORDS  = 1024,
    parameter int          ADDR_STEP  = 1,
    parameter logic [31:0] SEED       = 32'h0000_0005,
    parameter int          TIMEOUT    = 4096,
    parameter int          ERR_W      = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iStart,
    input  logic              iInvert,
    input  logic              avl_waitrequest,
    output logic [ADDR_W-1:0] avl_address,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] data_in,
    output logic              oBusy,
    output logic              oDone,
    output logic              oPass,
    output logic              oTimeout,
    output logic [ERR_W-1:0]  oErrCount,
    output logic [ADDR_W-1:0] oFirstErrAddr
);

    localparam int REPS  = DATA_W / 32;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_WAIT,
        DONE
    } state_t;

    // Full-width test word for a given 32-bit pattern value.
    function automatic logic [DATA_W-1:0] pattern(input logic [31:0] val, input logic inv);
        return {REPS{val}} ^ {DATA_W{inv}};
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;        // word index i
    logic [31:0]       val_q, val_d;        // SEED + i, kept alongside idx
    logic              inv_q, inv_d;        // invert latched at start
    logic [TMR_W-1:0]  tmr_q, tmr_d;        // cycles spent in READ_WAIT
    logic [ADDR_W-1:0] addr_q, addr_d;      // doubles as addr(i) for error capture
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              tout_q, tout_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] ferr_q, ferr_d;

    // Next-state and registered-output logic for the test sequencer.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        val_d   = val_q;
        inv_d   = inv_q;
        tmr_d   = tmr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        rdata_d = rdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tout_d  = tout_q;
        err_d   = err_q;
        ferr_d  = ferr_q;

        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    state_d = WRITE;
                    err_d   = '0;
                    tout_d  = 1'b0;
                    ferr_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    inv_d   = iInvert;
                    idx_d   = '0;
                    val_d   = SEED;
                    write_d = 1'b1;
                    addr_d  = BASE_ADDR;
                    wdata_d = pattern(SEED, iInvert);
                end
            end

            WRITE: begin
                if (!avl_waitrequest) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IDX_W'(1);
                        val_d   = val_q + 32'd1;
                        addr_d  = addr_q + STEP;
                        wdata_d = pattern(val_q + 32'd1, inv_q);
                    end else begin
                        state_d = READ_REQ;
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        addr_d  = BASE_ADDR;
                        idx_d   = '0;
                        val_d   = SEED;
                    end
                end
            end

            READ_REQ: begin
                if (!avl_waitrequest) begin
                    state_d = READ_WAIT;
                    read_d  = 1'b0;
                    tmr_d   = '0;
                end
            end

            READ_WAIT: begin
                if (avl_readdatavalid) begin
                    rdata_d = avl_readdata;
                    if (avl_readdata != pattern(val_q, inv_q)) begin
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                        if (err_q == '0) ferr_d = addr_q;
                    end
                    if (idx_q != LAST_IDX) begin
                        state_d = READ_REQ;
                        idx_d   = idx_q + IDX_W'(1);
                        val_d   = val_q + 32'd1;
                        addr_d  = addr_q + STEP;
                        read_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0) && !tout_q;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    // Valid data on the deadline edge still wins over the timeout.
                    state_d = DONE;
                    tout_d  = 1'b1;
                    if (err_q == '0) ferr_d = addr_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!iRST_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            val_q   <= '0;
            inv_q   <= 1'b0;
            tmr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tout_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            inv_q   <= inv_d;
            tmr_q   <= tmr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign avl_address   = addr_q;
    assign avl_writedata = wdata_q;
    assign avl_read      = read_q;
    assign avl_write     = write_q;
    assign data_in       = rdata_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;
    assign oPass         = pass_q;
    assign oTimeout      = tout_q;
    assign oErrCount     = err_q;
    assign oFirstErrAddr = ferr_q;

endmodule
